// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: stream-side handshake plus register-array bus for fifo_ctrl.
// master = upstream/downstream/array side, slave = the controller.
interface fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             mem_write_en;
  logic [ADDR-1:0]  mem_write_addr;
  logic [WIDTH-1:0] mem_write_data;
  logic [ADDR-1:0]  mem_read_addr;
  logic [WIDTH-1:0] mem_read_data;

  modport master (
    output in_valid, in_data, out_ready, mem_read_data,
    input  in_ready, out_valid, out_data,
           mem_write_en, mem_write_addr, mem_write_data, mem_read_addr
  );

  modport slave (
    input  in_valid, in_data, out_ready, mem_read_data,
    output in_ready, out_valid, out_data,
           mem_write_en, mem_write_addr, mem_write_data, mem_read_addr
  );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: valid/ready FIFO controller for an external register array
// (posedge write, combinational read). Pointers carry an extra wrap bit;
// full/empty are decoded from the occupancy counter.
// Optional registered almost_full/almost_empty: define FIFO_CTRL_STATUS_EN.
module fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDR     = 2,
  parameter int AF_LEVEL = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fifo_ctrl_if.slave    bus,
  output logic [ADDR:0] count,
  output logic          full,
  output logic          empty
`ifdef FIFO_CTRL_STATUS_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  // Reject illegal geometry at elaboration time
  if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR != $clog2(DEPTH)
      || AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("fifo_ctrl: illegal WIDTH/DEPTH/ADDR/AF_LEVEL combination");
  end

  localparam logic [ADDR:0] PTR_ONE    = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0] FULL_COUNT = (ADDR + 1)'(DEPTH);

  logic [ADDR:0] wr_ptr;
  logic [ADDR:0] rd_ptr;
  logic [ADDR:0] count_next;
  logic          push;
  logic          pop;
  logic          ptr_full;
  logic          ptr_empty;

  // Flags depend only on registered count, so in_ready never sees out_ready
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign ptr_full  = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) && (wr_ptr[ADDR] != rd_ptr[ADDR]);
  assign ptr_empty = (wr_ptr == rd_ptr);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Array side: write issued straight from the handshake, read at the head
  assign bus.mem_write_en   = push;
  assign bus.mem_write_addr = wr_ptr[ADDR-1:0];
  assign bus.mem_write_data = bus.in_data;
  assign bus.mem_read_addr  = rd_ptr[ADDR-1:0];
  assign bus.out_data       = bus.mem_read_data;

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + PTR_ONE;
    end else if (pop && !push) begin
      count_next = count - PTR_ONE;
    end
  end

  // Pointer and count registers; flush wins over push/pop, memory untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

`ifdef FIFO_CTRL_STATUS_EN
  localparam logic [ADDR:0] AF_COUNT = (ADDR + 1)'(AF_LEVEL);

  // Status flags are loaded from the same next count as the counter itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= AF_COUNT);
      almost_empty <= (count_next <= PTR_ONE);
    end
  end
`endif

  // Counter-derived full/empty must agree with the wrap-bit pointer relation
  assert property (@(posedge clk) disable iff (rst)
    (full == ptr_full) && (empty == ptr_empty));

endmodule
